// File: rtl/aoc_sched_pkg.sv
// Shared scheduler types: range FSM states, decimal power table and digit-length limit.
package aoc_sched_pkg;

    localparam int MAX_DIGS_DEFAULT = 12;

    typedef enum logic [3:0] {
        IDLE,
        DIG_LO,
        DIG_HI,
        SEL,
        ISSUE_ADD,
        WAIT_ADD,
        ISSUE_SUB,
        WAIT_SUB,
        NEXT,
        DONE
    } range_sched_state_t;

    // 10^d for d in 0..15; the constant loop bound keeps it synthesizable.
    function automatic logic [63:0] pow10(input logic [3:0] d);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(d)) r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_len.sv
// Sequential decimal digit counter: one comparison against 10^d per cycle, result clamped to MAX_DIGS.
module digit_len
    import aoc_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_DIGS   = MAX_DIGS_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            digs
);

    logic [DATA_WIDTH-1:0] r_x;
    logic [3:0]            r_d;
    logic                  r_busy;
    logic                  r_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x    <= '0;
            r_d    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_x    <= x;
                r_d    <= 4'd1;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if ((64'(r_x) < pow10(r_d)) || (r_d == 4'(MAX_DIGS))) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_d <= r_d + 4'd1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign digs = r_d;

endmodule

// File: rtl/range_sum_sched.sv
// Splits an ID range into per-digit-length engine queries and sums the results; keeps a grand total.
// Optional RANGE_SUM_SCHED_STATS_EN adds saturating stat_jobs / stat_busy counters.
module range_sum_sched
    import aoc_sched_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int LONG_DATA_WIDTH = 64,
    parameter int GROUP_N         = 2,
    parameter int MAX_DIGS        = MAX_DIGS_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rng_valid,
    output logic                       rng_ready,
    input  logic [DATA_WIDTH-1:0]      rng_lo,
    input  logic [DATA_WIDTH-1:0]      rng_hi,
    output logic                       eng_start,
    output logic [DATA_WIDTH-1:0]      eng_n,
    output logic [3:0]                 eng_n_digs,
    input  logic                       eng_done,
    input  logic [LONG_DATA_WIDTH-1:0] eng_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LONG_DATA_WIDTH-1:0] out_sum,
    output logic [LONG_DATA_WIDTH-1:0] total_out
`ifdef RANGE_SUM_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_jobs,
    output logic [31:0]                stat_busy
`endif
);

    range_sched_state_t          r_state, w_next;
    logic [DATA_WIDTH-1:0]       r_lo, r_hi, r_eng_n;
    logic [LONG_DATA_WIDTH-1:0]  r_acc, r_total;
    logic [3:0]                  r_dlo, r_dhi, r_d, r_eng_n_digs;

    logic                  w_dl_start, w_dl_busy, w_dl_done;
    logic [DATA_WIDTH-1:0] w_dl_x;
    logic [3:0]            w_dl_digs;
    logic                  w_empty, w_skip, w_need_sub;
    logic [DATA_WIDTH-1:0] w_add_n;

    digit_len #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIGS(MAX_DIGS)) u_digit_len (
        .clock (clock),
        .reset (reset),
        .start (w_dl_start),
        .x     (w_dl_x),
        .busy  (w_dl_busy),
        .done  (w_dl_done),
        .digs  (w_dl_digs)
    );

    assign w_empty    = r_lo > r_hi;
    assign w_skip     = ({28'd0, r_d} % 32'(GROUP_N)) != 32'd0;
    // Lengths above dlo start at 10^(d-1), so only the first length can need trimming below lo.
    assign w_need_sub = (r_d == r_dlo) && (r_lo != '0) && (64'(r_lo) != pow10(r_d - 4'd1));
    assign w_add_n    = (r_d == r_dhi) ? r_hi : DATA_WIDTH'(pow10(r_d) - 64'd1);

    always_comb begin
        w_next     = r_state;
        rng_ready  = 1'b0;
        eng_start  = 1'b0;
        out_valid  = 1'b0;
        w_dl_start = 1'b0;
        w_dl_x     = r_hi;
        case (r_state)
            IDLE: begin
                rng_ready  = !reset;
                w_dl_x     = rng_lo;
                w_dl_start = rng_valid;
                if (rng_valid) w_next = DIG_LO;
            end
            DIG_LO: begin
                if (w_empty) begin
                    w_next = DONE;
                end else if (w_dl_done && !w_dl_busy) begin
                    w_dl_start = 1'b1;
                    w_next     = DIG_HI;
                end
            end
            DIG_HI:    if (w_dl_done && !w_dl_busy) w_next = SEL;
            SEL:       w_next = w_skip ? NEXT : ISSUE_ADD;
            ISSUE_ADD: begin
                eng_start = 1'b1;
                w_next    = WAIT_ADD;
            end
            WAIT_ADD:  if (eng_done) w_next = w_need_sub ? ISSUE_SUB : NEXT;
            ISSUE_SUB: begin
                eng_start = 1'b1;
                w_next    = WAIT_SUB;
            end
            WAIT_SUB:  if (eng_done) w_next = NEXT;
            NEXT:      w_next = (r_d == r_dhi) ? DONE : SEL;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_acc        <= '0;
            r_total      <= '0;
            r_dlo        <= '0;
            r_dhi        <= '0;
            r_d          <= '0;
            r_eng_n      <= '0;
            r_eng_n_digs <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (rng_valid) begin
                    r_lo  <= rng_lo;
                    r_hi  <= rng_hi;
                    r_acc <= '0;
                end
                DIG_LO: if (w_dl_done) r_dlo <= w_dl_digs;
                DIG_HI: if (w_dl_done) begin
                    r_dhi <= (w_dl_digs > 4'(MAX_DIGS)) ? 4'(MAX_DIGS) : w_dl_digs;
                    r_d   <= r_dlo;
                end
                SEL: if (!w_skip) begin
                    r_eng_n      <= w_add_n;
                    r_eng_n_digs <= r_d;
                end
                WAIT_ADD: if (eng_done) begin
                    r_acc <= r_acc + eng_result;
                    if (w_need_sub) r_eng_n <= r_lo - DATA_WIDTH'(1);
                end
                WAIT_SUB: if (eng_done) r_acc <= r_acc - eng_result;
                NEXT:     if (r_d != r_dhi) r_d <= r_d + 4'd1;
                DONE:     if (out_ready) r_total <= r_total + r_acc;
                default: ;
            endcase
        end
    end

    assign eng_n      = r_eng_n;
    assign eng_n_digs = r_eng_n_digs;
    assign out_sum    = r_acc;
    assign total_out  = r_total;

`ifdef RANGE_SUM_SCHED_STATS_EN
    logic [31:0] r_stat_jobs, r_stat_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_jobs <= '0;
            r_stat_busy <= '0;
        end else begin
            if (eng_start && (r_stat_jobs != '1)) r_stat_jobs <= r_stat_jobs + 32'd1;
            if ((r_state != IDLE) && (r_stat_busy != '1)) r_stat_busy <= r_stat_busy + 32'd1;
        end
    end

    assign stat_jobs = r_stat_jobs;
    assign stat_busy = r_stat_busy;
`endif

endmodule

// File: tb/tb_range_sum_sched.sv
// Bench for range_sum_sched: behavioural engine with random latency, brute-force range reference.
module tb_range_sum_sched;

    logic        clock, reset;
    logic        rng_valid, rng_ready;
    logic [63:0] rng_lo, rng_hi;
    logic        eng_start;
    logic [63:0] eng_n;
    logic [3:0]  eng_n_digs;
    logic        eng_done;
    logic [63:0] eng_result;
    logic        out_valid, out_ready;
    logic [63:0] out_sum, total_out;
`ifdef RANGE_SUM_SCHED_STATS_EN
    logic [31:0] stat_jobs, stat_busy;
`endif

    int checks = 0;
    int errors = 0;
    int jobs_seen = 0;
    bit eng_busy = 0;
    longint unsigned model_total = 0;

    range_sum_sched #(.DATA_WIDTH(64), .LONG_DATA_WIDTH(64), .GROUP_N(2), .MAX_DIGS(12)) dut (
        .clock      (clock),
        .reset      (reset),
        .rng_valid  (rng_valid),
        .rng_ready  (rng_ready),
        .rng_lo     (rng_lo),
        .rng_hi     (rng_hi),
        .eng_start  (eng_start),
        .eng_n      (eng_n),
        .eng_n_digs (eng_n_digs),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .total_out  (total_out)
`ifdef RANGE_SUM_SCHED_STATS_EN
        ,
        .stat_jobs  (stat_jobs),
        .stat_busy  (stat_busy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned tpow(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int ndigits(input longint unsigned x);
        int d = 1;
        while (x >= tpow(d)) d++;
        return d;
    endfunction

    // An ID is invalid when its decimal string is some half repeated twice.
    function automatic bit is_twice(input longint unsigned x);
        int d = ndigits(x);
        if (d % 2 != 0) return 0;
        return (x / tpow(d / 2)) == (x % tpow(d / 2));
    endfunction

    function automatic longint unsigned ref_sum(input longint unsigned lo, input longint unsigned hi);
        longint unsigned s = 0;
        for (longint unsigned x = lo; x <= hi; x++) if (is_twice(x)) s += x;
        return s;
    endfunction

    // Engine: sum of d-digit doubled numbers k*(10^h+1) that are <= n.
    function automatic longint unsigned eng_model(input longint unsigned n, input int d);
        longint unsigned m, a, b, kmax;
        if (d == 0 || d % 2 != 0) return 0;
        m = tpow(d / 2) + 1;
        a = tpow(d / 2 - 1);
        b = tpow(d / 2) - 1;
        kmax = n / m;
        if (kmax > b) kmax = b;
        if (kmax < a) return 0;
        return m * (a + kmax) * (kmax - a + 1) / 2;
    endfunction

    initial begin
        longint unsigned q_n;
        int q_d, cnt;
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clock);
            #1;
            eng_done = 1'b0;
            if (reset) begin
                eng_busy = 0;
            end else if (eng_busy) begin
                if (eng_start) check("eng_overlap", eng_start, 1'b0);
                cnt--;
                if (cnt == 0) begin
                    check("eng_n_hold", eng_n, q_n);
                    check("eng_digs_hold", 64'(eng_n_digs), 64'(q_d));
                    eng_result = eng_model(q_n, q_d);
                    eng_done = 1'b1;
                    eng_busy = 0;
                end
            end else if (eng_start) begin
                eng_busy = 1;
                jobs_seen++;
                q_n = eng_n;
                q_d = int'(eng_n_digs);
                cnt = $urandom_range(3, 10);
            end
        end
    end

    task automatic send_range(input longint unsigned lo, input longint unsigned hi);
        bit got = 0;
        jobs_seen = 0;
        @(negedge clock);
        rng_lo = lo;
        rng_hi = hi;
        rng_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (rng_ready) begin
                got = 1;
                break;
            end
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        rng_valid = 1'b0;
        check("rng_accept", got, 1'b1);
    endtask

    task automatic run_range(input longint unsigned lo, input longint unsigned hi,
                             input longint unsigned exp_sum, input int exp_jobs, input int stall);
        bit got = 0;
        send_range(lo, hi);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        check("out_valid_wait", got, 1'b1);
        if (got) begin
            check("out_sum", out_sum, exp_sum);
            if (exp_jobs >= 0) check("eng_jobs", 64'(jobs_seen), 64'(exp_jobs));
            for (int s = 0; s < stall; s++) begin
                @(negedge clock);
                check("stall_valid", out_valid, 1'b1);
                check("stall_sum", out_sum, exp_sum);
            end
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            out_ready = 1'b0;
            model_total += exp_sum;
            check("total_out", total_out, model_total);
            check("out_valid_drop", out_valid, 1'b0);
            check("rng_ready_back", rng_ready, 1'b1);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_rng_ready", rng_ready, 1'b0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_eng_n", eng_n, 64'd0);
        check("rst_eng_digs", 64'(eng_n_digs), 64'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 64'd0);
        check("rst_total", total_out, 64'd0);
    endtask

    initial begin
        longint unsigned lo, hi;
        reset = 1'b1;
        rng_valid = 1'b0;
        rng_lo = '0;
        rng_hi = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("ready_after_reset", rng_ready, 1'b1);

        run_range(11, 22, 33, 2, 5);
        run_range(95, 115, 99, 2, 0);
        run_range(998, 1012, 1010, 1, 0);
        run_range(1, 9, 0, 0, 0);
        run_range(30, 20, 0, 0, 0);

        // Reset while the first ADD query is outstanding.
        send_range(11, 22);
        begin
            bit hit = 0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clock);
                if (eng_busy) begin
                    hit = 1;
                    break;
                end
            end
            check("reach_wait_add", hit, 1'b1);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset = 1'b0;
        model_total = 0;
        @(posedge clock);
        #1;
        check("ready_after_midreset", rng_ready, 1'b1);
        run_range(11, 22, 33, 2, 0);

        for (int i = 0; i < 20; i++) begin
            lo = $urandom_range(0, 32'(tpow($urandom_range(1, 7))));
            if ($urandom_range(0, 7) == 0 && lo > 0) hi = $urandom_range(0, 32'(lo - 1));
            else hi = lo + $urandom_range(0, 3000);
            run_range(lo, hi, (lo > hi) ? 0 : ref_sum(lo, hi), -1, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
